// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage with a registered carry walks the
// operands LSB-first over WIDTH cycles. Operands are captured on acceptance,
// so the inputs are free to change while the addition runs. The result and
// carry-out are held until the next operation completes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_sh_s;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sh_s_next;

  // The single full-adder stage operating on the current LSBs.
  assign w_s         = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
  assign w_c         = (r_sh_a[0] & r_sh_b[0]) | (r_carry & (r_sh_a[0] ^ r_sh_b[0]));
  assign w_sh_s_next = {w_s, r_sh_s[WIDTH-1:1]};

  // start only matters while idle; the last bit is the one with cnt at WIDTH-1.
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign Sum  = r_sum;
  assign Cout = r_cout;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE waits for start, RUN lasts WIDTH cycles, DONE is one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on acceptance, shift one bit per RUN cycle, publish at the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sh_s  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_sh_a  <= A;
      r_sh_b  <= B;
      r_sh_s  <= '0;
      r_carry <= Cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
      r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
      r_sh_s  <= w_sh_s_next;
      r_carry <= w_c;
      // Hold the counter at its final value rather than letting it wrap.
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_sum  <= w_sh_s_next;
        r_cout <= w_c;
      end
    end
  end

endmodule
